// File: rtl/instr_cycle_fsm.sv
// Eight-phase instruction-cycle controller: drives fetch, execute and store strobes from phase, opcode and zero.
// Optional INSTR_HALT_LATCH_EN: HLT latches a sticky halted state that only reset clears.
module instr_cycle_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  localparam logic [2:0] OP_HLT  = 3'd0;
  localparam logic [2:0] OP_SKZ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ANDD = 3'd3;
  localparam logic [2:0] OP_XORR = 3'd4;
  localparam logic [2:0] OP_LDA  = 3'd5;
  localparam logic [2:0] OP_STO  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  // Bit positions inside the packed strobe vector
  localparam int unsigned B_INC  = 7;
  localparam int unsigned B_LACC = 6;
  localparam int unsigned B_LPC  = 5;
  localparam int unsigned B_RD   = 4;
  localparam int unsigned B_WR   = 3;
  localparam int unsigned B_LIR  = 2;
  localparam int unsigned B_DCT  = 1;
  localparam int unsigned B_HALT = 0;

  function automatic state_t next_phase(input state_t ph);
    case (ph)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      S5:      return S6;
      S6:      return S7;
      S7:      return S0;
      default: return S0;
    endcase
  endfunction

  function automatic logic [7:0] decode(input state_t ph, input logic [2:0] op, input logic z);
    logic [7:0] v;
    logic       is_alu;
    logic       is_jmp;
    logic       is_sto;
    logic       is_skz;
    v      = 8'd0;
    is_alu = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    is_jmp = (op == OP_JMP);
    is_sto = (op == OP_STO);
    is_skz = (op == OP_SKZ);
    case (ph)
      S0: begin
        v[B_RD]  = 1'b1;
        v[B_LIR] = 1'b1;
      end
      S1: begin
        v[B_RD]  = 1'b1;
        v[B_LIR] = 1'b1;
        v[B_INC] = 1'b1;
      end
      S2: v = 8'd0;
      S3: begin
        v[B_INC]  = 1'b1;
        v[B_HALT] = (op == OP_HLT);
      end
      S4: begin
        v[B_LPC] = is_jmp;
        v[B_RD]  = is_alu;
        v[B_DCT] = is_sto;
      end
      S5: begin
        v[B_RD]   = is_alu;
        v[B_LACC] = is_alu;
        v[B_INC]  = (is_skz && z) || is_jmp;
        v[B_LPC]  = is_jmp;
        v[B_WR]   = is_sto;
        v[B_DCT]  = is_sto;
      end
      S6: begin
        v[B_DCT] = is_sto;
        v[B_RD]  = is_alu;
      end
      S7: v[B_INC] = is_skz && z;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_strobe;
  logic [7:0] w_strobe_nxt;

`ifdef INSTR_HALT_LATCH_EN
  logic r_halted;
  logic w_halted_nxt;

  // Next phase/strobes; a latched halt outranks ena and parks the sequencer in S4
  always_comb begin
    w_state_nxt  = r_state;
    w_strobe_nxt = 8'd0;
    w_halted_nxt = r_halted;
    if (r_halted) begin
      w_state_nxt          = S4;
      w_strobe_nxt[B_HALT] = 1'b1;
    end else if (!ena) begin
      w_state_nxt = S0;
    end else begin
      w_strobe_nxt = decode(r_state, opcode, zero);
      w_state_nxt  = next_phase(r_state);
      w_halted_nxt = (r_state == S3) && (opcode == OP_HLT);
    end
  end

  // Phase, strobe and halted-flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S0;
      r_strobe <= 8'd0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_strobe_nxt;
      r_halted <= w_halted_nxt;
    end
  end
`else
  // Next phase/strobes; ena low abandons the instruction and returns to S0
  always_comb begin
    w_state_nxt  = r_state;
    w_strobe_nxt = 8'd0;
    if (!ena) begin
      w_state_nxt = S0;
    end else begin
      w_strobe_nxt = decode(r_state, opcode, zero);
      w_state_nxt  = next_phase(r_state);
    end
  end

  // Phase and strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S0;
      r_strobe <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end
`endif

  assign inc_pc      = r_strobe[B_INC];
  assign load_acc    = r_strobe[B_LACC];
  assign load_pc     = r_strobe[B_LPC];
  assign rd          = r_strobe[B_RD];
  assign wr          = r_strobe[B_WR];
  assign load_ir     = r_strobe[B_LIR];
  assign datactl_ena = r_strobe[B_DCT];
  assign halt        = r_strobe[B_HALT];

endmodule

// File: tb/tb_instr_cycle_fsm.sv
// Scoreboard bench for instr_cycle_fsm: a phase-counting reference model queues expected strobes, a monitor compares.
module tb_instr_cycle_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic [2:0] opcode = 3'd5;
  logic       zero = 1'b0;
  logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int m_phase = 0;
  bit m_halted = 1'b0;

  instr_cycle_fsm dut (
    .clk(clk), .reset(reset), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  // Strobes written straight from the phase table; packed as {inc,lacc,lpc,rd,wr,lir,dct,halt}
  function automatic logic [7:0] spec_strobes(input int ph, input int op, input bit z);
    bit inc, lacc, lpc, r, w, lir, dct, h;
    bit alu;
    alu = (op >= 2 && op <= 5);
    {inc, lacc, lpc, r, w, lir, dct, h} = 8'd0;
    if (ph == 0) begin r = 1; lir = 1; end
    if (ph == 1) begin r = 1; lir = 1; inc = 1; end
    if (ph == 3) begin inc = 1; h = (op == 0); end
    if (ph == 4) begin lpc = (op == 7); r = alu; dct = (op == 6); end
    if (ph == 5) begin
      r = alu; lacc = alu; lpc = (op == 7); inc = (op == 7) || (op == 1 && z);
      w = (op == 6); dct = (op == 6);
    end
    if (ph == 6) begin dct = (op == 6); r = alu; end
    if (ph == 7) inc = (op == 1 && z);
    return {inc, lacc, lpc, r, w, lir, dct, h};
  endfunction

  task automatic step(input bit r, input bit e, input int op, input bit z);
    logic [7:0] e_v;
    @(negedge clk);
    reset = r; ena = e; opcode = 3'(op); zero = z;
    if (r) begin
      e_v = 8'd0; m_phase = 0; m_halted = 1'b0;
`ifdef INSTR_HALT_LATCH_EN
    end else if (m_halted) begin
      e_v = 8'b0000_0001;
`endif
    end else if (!e) begin
      e_v = 8'd0; m_phase = 0;
    end else begin
      e_v = spec_strobes(m_phase, op, z);
`ifdef INSTR_HALT_LATCH_EN
      if (m_phase == 3 && op == 0) m_halted = 1'b1;
`endif
      m_phase = (m_phase + 1) % 8;
    end
    exp_q.push_back(e_v);
  endtask

  task automatic run(input int n, input int op, input bit z);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, op, z);
  endtask

  // Monitor: every cycle the DUT presents a strobe word; pop and compare it
  always @(posedge clk) begin
    logic [7:0] got, want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL strobes t=%0t got=%b want=%b", $time, got, want);
      end
      total++;
      if ((wr === 1'b1) && (datactl_ena !== 1'b1 || rd !== 1'b0)) begin
        bad++;
        $display("FAIL wr_invariant t=%0t wr=%b dct=%b rd=%b want dct=1 rd=0", $time, wr, datactl_ena, rd);
      end
    end
  end

  initial begin
    // Reset held two cycles with ena high, then LDA and the following fetch
    step(1, 1, 5, 0); step(1, 1, 5, 0);
    run(9, 5, 0);
    step(1, 1, 1, 1);
    run(8, 1, 1);
    run(8, 1, 0);
    run(8, 6, 0);
    run(8, 2, 1);
    run(8, 3, 0);
    run(8, 4, 1);
    // HLT: pulse-and-continue or sticky halt depending on build
    run(25, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 7, 0);
    // JMP abandoned in S4, then restart
    run(4, 7, 0);
    step(0, 0, 7, 0);
    run(9, 7, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end
    step(1, 0, 0, 0);
    @(posedge clk); #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
